// File: rtl/alu_operand_sequencer.sv
// Stepped A/B/opcode entry for the lab-board ALU from one switch bank and two buttons.
// Buttons are synchronized and debounced; the ALU result is captured for display.
`timescale 1ns/1ps
module alu_operand_sequencer #(
    parameter int N               = 4,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] data_sw,
    input  logic [2:0]   op_sw,
    input  logic [1:0]   arith_sw,
    input  logic         btn_next,
    input  logic         btn_clear,
    output logic [N-1:0] a,
    output logic [N-1:0] b,
    output logic [2:0]   op,
    output logic         op_sum,
    output logic         op_subt,
    input  logic [N-1:0] alu_result,
    input  logic [3:0]   alu_flags,
    output logic [N-1:0] result_q,
    output logic [3:0]   flags_q,
    output logic         done,
    output logic [2:0]   stage
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] S_A    = 3'd0;
    localparam logic [2:0] S_B    = 3'd1;
    localparam logic [2:0] S_OP   = 3'd2;
    localparam logic [2:0] S_EXEC = 3'd3;
    localparam logic [2:0] S_SHOW = 3'd4;

    // bit 0 = next, bit 1 = clear
    logic [1:0]    w_raw;
    logic [1:0]    r_sync1;
    logic [1:0]    r_sync2;
    logic [1:0]    r_stable;
    logic [1:0]    r_stable_q;
    logic [1:0]    r_press;
    logic [CW-1:0] r_cnt [2];
    logic          w_next_p;
    logic          w_clear_p;

    assign w_raw     = {btn_clear, btn_next};
    assign w_next_p  = r_press[0];
    assign w_clear_p = r_press[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_stable   <= '0;
            r_stable_q <= '0;
            r_press    <= '0;
            r_cnt[0]   <= '0;
            r_cnt[1]   <= '0;
        end else begin
            r_sync1    <= w_raw;
            r_sync2    <= r_sync1;
            r_stable_q <= r_stable;
            r_press    <= r_stable & ~r_stable_q;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_stable[i] <= r_sync2[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    logic [2:0]   r_state;
    logic [N-1:0] r_a;
    logic [N-1:0] r_b;
    logic [2:0]   r_op;
    logic         r_op_sum;
    logic         r_op_subt;
    logic [N-1:0] r_result;
    logic [3:0]   r_flags;
    logic         r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_A;
            r_a       <= '0;
            r_b       <= '0;
            r_op      <= '0;
            r_op_sum  <= 1'b0;
            r_op_subt <= 1'b0;
            r_result  <= '0;
            r_flags   <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // clear has priority; a simultaneous next is dropped
            if (w_clear_p) begin
                r_state   <= S_A;
                r_a       <= '0;
                r_b       <= '0;
                r_op      <= '0;
                r_op_sum  <= 1'b0;
                r_op_subt <= 1'b0;
                r_result  <= '0;
                r_flags   <= '0;
            end else begin
                case (r_state)
                    S_A: if (w_next_p) begin
                        r_a     <= data_sw;
                        r_state <= S_B;
                    end
                    S_B: if (w_next_p) begin
                        r_b     <= data_sw;
                        r_state <= S_OP;
                    end
                    S_OP: if (w_next_p) begin
                        r_op      <= op_sw;
                        r_op_sum  <= arith_sw[0];
                        r_op_subt <= arith_sw[1];
                        r_state   <= S_EXEC;
                    end
                    S_EXEC: begin
                        r_result <= alu_result;
                        r_flags  <= alu_flags;
                        r_done   <= 1'b1;
                        r_state  <= S_SHOW;
                    end
                    S_SHOW: if (w_next_p) begin
                        r_state <= S_A;
                    end
                    default: r_state <= S_A;
                endcase
            end
        end
    end

    logic [2:0] w_stage;

    always_comb begin
        w_stage = 3'b000;
        case (r_state)
            S_A:     w_stage = 3'b001;
            S_B:     w_stage = 3'b010;
            S_OP:    w_stage = 3'b100;
            default: w_stage = 3'b000;
        endcase
    end

    assign a        = r_a;
    assign b        = r_b;
    assign op       = r_op;
    assign op_sum   = r_op_sum;
    assign op_subt  = r_op_subt;
    assign result_q = r_result;
    assign flags_q  = r_flags;
    assign done     = r_done;
    assign stage    = w_stage;

endmodule
